// File: rtl/debounce_multi_if.sv
// Bundle of pin-side and filtered-side signals for the multi-channel debouncer.
//   din      raw asynchronous button/switch levels (WIDTH)
//   dout     debounced levels (WIDTH)
//   rise_p   1-cycle pulse on dout 0->1 (WIDTH)
//   fall_p   1-cycle pulse on dout 1->0 (WIDTH)
//   long_p   1-cycle pulse after dout held 1 for HOLD_MAX cycles (WIDTH)
//   any_chg  OR of all rise_p/fall_p bits
// master: board/stimulus side; slave: the debouncer.
interface debounce_multi_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] rise_p;
  logic [WIDTH-1:0] fall_p;
  logic [WIDTH-1:0] long_p;
  logic             any_chg;

  modport master (
    output din,
    input  dout, rise_p, fall_p, long_p, any_chg
  );

  modport slave (
    input  din,
    output dout, rise_p, fall_p, long_p, any_chg
  );
endinterface

// File: rtl/debounce_multi.sv
// Multi-channel button/switch debouncer.
// Each channel: SYNC_STAGES-deep synchroniser, then a stable-count filter that accepts a new
// level only after it has been seen for CNT_MAX consecutive cycles. Registered rise/fall
// pulses accompany each accepted change; optional long-press pulse after HOLD_MAX cycles high.
// Ports:
//   clk  system clock
//   rst  asynchronous reset, active-high
//   bus  debounce_multi_if.slave (din in; dout, rise_p, fall_p, long_p, any_chg out)
module debounce_multi #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned CNT_MAX     = 100000,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_MAX    = 0,
  parameter bit          RST_VAL     = 1'b0
) (
  input logic             clk,
  input logic             rst,
  debounce_multi_if.slave bus
);

  // Counter only ever reaches CNT_MAX-1, so $clog2(CNT_MAX) bits never wrap.
  localparam int unsigned CntW = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] long_pulse;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CntW-1:0]        cnt_q;
    logic                   dout_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q <= {SYNC_STAGES{RST_VAL}};
        cnt_q  <= '0;
        dout_q <= RST_VAL;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.din[g]};
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (s == dout_q) begin
          // Stable, or a glitch ended mid-check: restart from zero.
          cnt_q <= '0;
        end else if (cnt_q == CntW'(CNT_MAX - 1)) begin
          dout_q <= s;
          cnt_q  <= '0;
          rise_q <= s;
          fall_q <= ~s;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign dout[g] = dout_q;
    assign rise[g] = rise_q;
    assign fall[g] = fall_q;

    if (HOLD_MAX > 0) begin : g_hold
      // hold saturates at HOLD_MAX so long_p fires exactly once per press.
      localparam int unsigned HoldW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;
      logic [HoldW-1:0] hold_q;
      logic             long_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hold_q <= '0;
          long_q <= 1'b0;
        end else begin
          long_q <= 1'b0;
          if (!dout_q) begin
            hold_q <= '0;
          end else if (hold_q != HoldW'(HOLD_MAX)) begin
            hold_q <= hold_q + 1'b1;
            long_q <= (hold_q == HoldW'(HOLD_MAX - 1));
          end
        end
      end

      assign long_pulse[g] = long_q;
    end else begin : g_no_hold
      assign long_pulse[g] = 1'b0;
    end
  end

  assign bus.dout    = dout;
  assign bus.rise_p  = rise;
  assign bus.fall_p  = fall;
  assign bus.long_p  = long_pulse;
  assign bus.any_chg = |(rise | fall);

endmodule
